piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, 4, bits per parallel word (legal range 2..32).
REQ-002 SHALL have parameter: MSB_FIRST, 1, 1 = bit WIDTH-1 shifted out first; 0 = bit 0 shifted out first.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port: load_valid  input  1  load_data holds a word to serialize.
REQ-006 SHALL have port: load_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port: load_data  input  WIDTH  parallel word.
REQ-008 SHALL have port: shift_en  input  1  consumer takes the current serial bit at this edge.
REQ-009 SHALL have port: ser_out  output  1  current serial bit.
REQ-010 SHALL have port: ser_valid  output  1  ser_out carries a valid data bit.
REQ-011 SHALL have port: ser_last  output  1  current bit is the final bit of its word.
REQ-012 SHALL have port: busy  output  1  shifter or holding buffer occupied.

Function
REQ-013 SHALL contain a shift register, a bit counter of width clog2(WIDTH), and a one-entry holding buffer with a full flag.
REQ-014 SHALL implement states IDLE (shifter empty) and SHIFT (shifter holds a word); ser_valid = (state == SHIFT).
REQ-015 SHALL drive load_ready = NOT buffer_full, as a registered value with no combinational path from load_valid.
REQ-016 SHALL treat a word as accepted at a rising edge where load_valid and load_ready are both 1.
REQ-017 SHALL route the accepted word directly into the shifter if the shifter is in IDLE, or is finishing its last bit at this edge, and the buffer is empty; otherwise SHALL store it in the buffer.
REQ-018 Latency: a word accepted at edge N into an empty block SHALL present its first bit on ser_out with ser_valid=1 immediately after edge N.
REQ-019 SHALL advance exactly one bit per edge with shift_en=1 in SHIFT, and SHALL hold ser_out, the counter and the shifter when shift_en=0.
REQ-020 SHALL assert ser_last when the counter equals WIDTH-1.
REQ-021 At an edge with shift_en=1 and ser_last=1, the shifter SHALL:
  - load from the buffer if the buffer is full, clearing the buffer;
  - else load the word accepted at that same edge;
  - else go to IDLE.
REQ-022 Back-to-back words SHALL stream with no idle cycle: WIDTH consumed bits per word.
REQ-023 shift_en in IDLE SHALL be ignored.
REQ-024 In IDLE, ser_out SHALL be 0.
REQ-025 busy SHALL equal ser_valid OR buffer_full.
REQ-026 Any change to load_data while load_ready=0 SHALL have no effect.

Reset
REQ-027 While rst=0, state SHALL be IDLE, the counter 0, the shifter and buffer 0, and buffer_full 0.
REQ-028 While rst=0, outputs SHALL be load_ready=1, ser_out=0, ser_valid=0, ser_last=0, busy=0.
REQ-029 Reset asserted mid-word SHALL discard the partial word and any buffered word immediately, without waiting for a clock edge.
REQ-030 After reset release, the first edge SHALL be able to accept a word.

Structure
REQ-031 Package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and default constants (DEFAULT_WIDTH=4).
REQ-032 The holding buffer SHALL be a separate sub-module piso_hold_buf (data register + full flag, write/read strobes); all other logic SHALL be in piso_serializer.

Verification
REQ-033 Reset: rst=0 for 2 cycles with random inputs -> load_ready=1, ser_valid=0, busy=0, ser_out=0 throughout.
REQ-034 Single word: WIDTH=4, MSB_FIRST=1, load 4'b1011 with shift_en=1 -> ser_out 1,0,1,1 on 4 consecutive cycles; ser_last only on the 4th; then IDLE.
REQ-035 Back-to-back: load 4'hA, then 4'h5 one cycle later -> 8 contiguous bits 1,0,1,0,0,1,0,1; ser_valid never drops.
REQ-036 Backpressure: shift_en=0 with 3 words offered -> 2 accepted (shifter + buffer), then load_ready=0; ser_out held; releasing shift_en drains both words in order.
REQ-037 Mid-word reset: assert rst=0 after 2 bits of 4'hC with a word buffered -> ser_valid=0 and busy=0 with no clock edge; after release, 4'h3 serializes cleanly as 0,0,1,1.
REQ-038 LSB-first: MSB_FIRST=0, WIDTH=8, load 8'h81 then 8'h02 -> bits 1,0,0,0,0,0,0,1 then 0,1,0,0,0,0,0,0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and default constants for the parallel-in / serial-out serializer.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH     = 4;
   localparam bit DEFAULT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding buffer: a data register plus a full flag, with write/read strobes.
module piso_hold_buf #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic [WIDTH-1:0] data,
   output logic             full
);

   logic [WIDTH-1:0] data_reg;
   logic             full_reg;

   // wr is only issued while empty and rd only while full, so they never collide
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_reg <= '0;
         full_reg <= 1'b0;
      end else if (wr) begin
         data_reg <= wr_data;
         full_reg <= 1'b1;
      end else if (rd) begin
         full_reg <= 1'b0;
      end
   end

   assign data = data_reg;
   assign full = full_reg;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a one-word holding buffer, so that
// back-to-back words stream without a gap and the producer sees registered backpressure.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [CW-1:0]    cnt_reg, cnt_next;

   logic             buf_wr, buf_rd, buf_full;
   logic [WIDTH-1:0] buf_data;

   logic accept, last_bit, finish, direct;

   assign accept   = load_valid & ~buf_full;
   assign last_bit = (state_reg == SHIFT) && (cnt_reg == CW'(WIDTH - 1));
   assign finish   = last_bit & shift_en;
   // A new word bypasses the buffer whenever the shifter is free at this edge
   assign direct   = accept & ((state_reg == IDLE) | finish);
   assign buf_wr   = accept & ~direct;

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      cnt_next   = cnt_reg;
      buf_rd     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               shift_next = load_data;
               cnt_next   = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               if (last_bit) begin
                  cnt_next = '0;
                  if (buf_full) begin
                     shift_next = buf_data;
                     buf_rd     = 1'b1;
                  end else if (accept) begin
                     shift_next = load_data;
                  end else begin
                     shift_next = '0;
                     state_next = IDLE;
                  end
               end else begin
                  cnt_next   = cnt_reg + CW'(1);
                  shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                         : {1'b0, shift_reg[WIDTH-1:1]};
               end
            end
         end
         default: begin
            state_next = IDLE;
            shift_next = '0;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         cnt_reg   <= cnt_next;
      end
   end

   piso_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
      .clk     (clk),
      .rst     (rst),
      .wr      (buf_wr),
      .wr_data (load_data),
      .rd      (buf_rd),
      .data    (buf_data),
      .full    (buf_full)
   );

   assign ser_valid  = (state_reg == SHIFT);
   assign ser_out    = ser_valid & (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
   assign ser_last   = last_bit;
   assign load_ready = ~buf_full;
   assign busy       = ser_valid | buf_full;

endmodule
